// File: rtl/fetch_buffer.sv
// fetch_buffer: fetch PC + I-cache request + circular instruction queue feeding 3-way dispatch.
// Optional WFI fetch halt enabled by defining FETCH_HALT_STOP_EN.
package fetch_buffer_pkg;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        valid;
  } fetch_dispatch_packet_t;
endpackage

module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int          WIDTH    = 3,
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  squash,
  input  logic [31:0]                           target_pc,
  output logic                                  icache_req_valid,
  output logic [31:0]                           icache_req_addr,
  input  logic                                  icache_rsp_valid,
  input  logic [63:0]                           icache_rsp_data,
  input  logic [$clog2(WIDTH+1)-1:0]            dispatch_num,
  output fetch_dispatch_packet_t [WIDTH-1:0]    fetch_packet_out,
  output logic [$clog2(DEPTH+1)-1:0]            free_slots
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [31:0] WFI = 32'h10500073;
  logic [31:0] pc;
  logic [PW-1:0] head, tail, tail_p1;
  logic [CW-1:0] count, deq;
  logic [31:0] inst_q [DEPTH];
  logic [31:0] pc_q [DEPTH];
  logic [31:0] lo, hi, first_inst;
  logic [1:0] enq;
  logic two, req, hit, cut, stopped;
`ifdef FETCH_HALT_STOP_EN
  // A WFI in the low word drops the high word; any enqueued WFI stops fetch until redirect.
  assign cut = two && lo == WFI;
  always_ff @(posedge clock or posedge reset)
    if (reset) stopped <= 1'b0;
    else if (squash) stopped <= 1'b0;
    else if (hit && (first_inst == WFI || (two && !cut && hi == WFI))) stopped <= 1'b1;
`else
  assign cut = 1'b0;
  assign stopped = 1'b0;
`endif
  always_comb begin
    lo = icache_rsp_data[31:0];
    hi = icache_rsp_data[63:32];
    two = !pc[2];
    first_inst = two ? lo : hi;
    req = !squash && !stopped && (CW'(DEPTH) - count >= CW'(2));
    hit = req && icache_rsp_valid;
    enq = !hit ? 2'd0 : (two && !cut) ? 2'd2 : 2'd1;
    deq = (CW'(dispatch_num) > count) ? count : CW'(dispatch_num);
    tail_p1 = tail + PW'(1);
  end
  assign icache_req_valid = req && !reset;
  assign icache_req_addr = {pc[31:3], 3'b000};
  assign free_slots = CW'(DEPTH) - count;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      pc <= RESET_PC;
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (squash) begin
      pc <= target_pc;
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (hit) pc <= pc + (two ? 32'd8 : 32'd4);
      tail <= tail + PW'(enq);
      head <= head + PW'(deq);
      count <= count + CW'(enq) - deq;
    end
  always_ff @(posedge clock)
    if (hit) begin
      inst_q[tail] <= first_inst;
      pc_q[tail] <= pc;
      if (enq == 2'd2) begin
        inst_q[tail_p1] <= hi;
        pc_q[tail_p1] <= pc + 32'd4;
      end
    end
  for (genvar i = 0; i < WIDTH; i++) begin : g_slot
    logic [PW-1:0] idx;
    assign idx = head + PW'(i);
    assign fetch_packet_out[i] = (CW'(i) < count) ? {inst_q[idx], pc_q[idx], pc_q[idx] + 32'd4, 1'b1} : '0;
  end
endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: random + directed stimulus checked against a queue-based fetch model.
module tb_fetch_buffer;
  import fetch_buffer_pkg::*;
  localparam int WIDTH = 3;
  localparam int DEPTH = 8;
  localparam logic [31:0] WFI = 32'h10500073;
`ifdef FETCH_HALT_STOP_EN
  localparam bit HALT = 1'b1;
`else
  localparam bit HALT = 1'b0;
`endif
  logic clock = 0, reset = 1, squash = 0, icache_rsp_valid = 0, icache_req_valid;
  logic [31:0] target_pc = 0, icache_req_addr;
  logic [63:0] icache_rsp_data = 0;
  logic [1:0] dispatch_num = 0;
  fetch_dispatch_packet_t [WIDTH-1:0] fetch_packet_out;
  logic [3:0] free_slots;
  int checks = 0, errors = 0;
  logic [31:0] mq_inst[$], mq_pc[$];
  logic [31:0] mpc = 32'h0;
  bit mstop = 0;
  always #5 clock = ~clock;
  fetch_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset), .squash(squash), .target_pc(target_pc),
    .icache_req_valid(icache_req_valid), .icache_req_addr(icache_req_addr),
    .icache_rsp_valid(icache_rsp_valid), .icache_rsp_data(icache_rsp_data),
    .dispatch_num(dispatch_num), .fetch_packet_out(fetch_packet_out), .free_slots(free_slots)
  );
  function automatic logic [31:0] inst_at(input logic [31:0] a);
    return a == 32'h10 ? WFI : {a[15:0] ^ 16'hbeef, a[15:0]};
  endfunction
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic bit exp_req();
    return !squash && !mstop && (DEPTH - mq_pc.size() >= 2);
  endfunction
  function automatic fetch_dispatch_packet_t exp_pkt(input int i);
    exp_pkt = '0;
    if (i < mq_pc.size()) begin
      exp_pkt.inst = mq_inst[i];
      exp_pkt.pc = mq_pc[i];
      exp_pkt.npc = mq_pc[i] + 32'd4;
      exp_pkt.valid = 1'b1;
    end
  endfunction
  task automatic push(input logic [31:0] inst, input logic [31:0] p);
    mq_inst.push_back(inst);
    mq_pc.push_back(p);
    if (HALT && inst == WFI) mstop = 1;
  endtask
  task automatic model_update();
    logic [31:0] lo, hi;
    bit req;
    lo = icache_rsp_data[31:0];
    hi = icache_rsp_data[63:32];
    req = exp_req();
    if (squash) begin
      mq_inst.delete();
      mq_pc.delete();
      mpc = target_pc;
      mstop = 0;
    end else begin
      repeat (int'(dispatch_num)) begin
        void'(mq_inst.pop_front());
        void'(mq_pc.pop_front());
      end
      if (req && icache_rsp_valid) begin
        if (!mpc[2]) begin
          push(lo, mpc);
          if (!(HALT && lo == WFI)) push(hi, mpc + 32'd4);
          mpc = mpc + 32'd8;
        end else begin
          push(hi, mpc);
          mpc = mpc + 32'd4;
        end
      end
    end
  endtask
  task automatic drive(input bit sq, input logic [31:0] tgt, input bit rv, input int dn);
    logic [31:0] a;
    a = {mpc[31:3], 3'b000};
    squash = sq;
    target_pc = tgt;
    icache_rsp_valid = rv;
    dispatch_num = 2'(dn);
    icache_rsp_data = {inst_at(a + 32'd4), inst_at(a)};
    assert (dn <= mq_pc.size()) else $error("dispatch_num %0d exceeds count %0d", dn, mq_pc.size());
    #1;
  endtask
  task automatic tick();
    @(posedge clock);
    model_update();
    #1;
  endtask
  always @(negedge clock)
    if (!reset) begin
      chk("req_valid", icache_req_valid, exp_req());
      chk("req_addr", icache_req_addr, {mpc[31:3], 3'b000});
      chk("free_slots", free_slots, DEPTH - mq_pc.size());
      for (int i = 0; i < WIDTH; i++) chk($sformatf("slot%0d", i), fetch_packet_out[i], exp_pkt(i));
    end
  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("rst_req_valid", icache_req_valid, 0);
    chk("rst_free_slots", free_slots, 8);
    chk("rst_slot0_valid", fetch_packet_out[0].valid, 0);
    chk("rst_slot2_valid", fetch_packet_out[2].valid, 0);
    reset = 0;
    drive(0, 0, 1, 0);
    chk("first_req_valid", icache_req_valid, 1);
    chk("first_req_addr", icache_req_addr, 32'h0);
    tick();
    drive(0, 0, 1, 0);
    chk("s0_pc", fetch_packet_out[0].pc, 32'h0);
    chk("s0_npc", fetch_packet_out[0].npc, 32'h4);
    chk("s1_pc", fetch_packet_out[1].pc, 32'h4);
    chk("s1_npc", fetch_packet_out[1].npc, 32'h8);
    chk("s1_valid", fetch_packet_out[1].valid, 1);
    chk("s2_valid", fetch_packet_out[2].valid, 0);
    tick();
    drive(1, 32'h104, 1, 0);
    chk("sq_req_valid", icache_req_valid, 0);
    tick();
    drive(0, 0, 1, 0);
    chk("odd_req_addr", icache_req_addr, 32'h100);
    tick();
    drive(0, 0, 1, 0);
    chk("odd_s0_pc", fetch_packet_out[0].pc, 32'h104);
    chk("odd_s0_inst", fetch_packet_out[0].inst, inst_at(32'h104));
    chk("odd_s1_valid", fetch_packet_out[1].valid, 0);
    chk("odd_next_addr", icache_req_addr, 32'h108);
    tick();
    repeat (2) begin
      drive(0, 0, 1, 0);
      tick();
    end
    drive(0, 0, 1, 0);
    chk("full_free_slots", free_slots, 1);
    chk("full_req_valid", icache_req_valid, 0);
    tick();
    drive(0, 0, 1, 3);
    tick();
    drive(0, 0, 1, 1);
    chk("pop3_s0_pc", fetch_packet_out[0].pc, 32'h110);
    chk("pop3_free", free_slots, 4);
    tick();
    drive(0, 0, 1, 2);
    chk("pop1_s0_pc", fetch_packet_out[0].pc, 32'h114);
    tick();
    drive(1, 32'h200, 1, 2);
    chk("pop2_s0_pc", fetch_packet_out[0].pc, 32'h11c);
    chk("pop2_s4_free", free_slots, 3);
    tick();
    drive(0, 0, 0, 0);
    chk("sq_s0_valid", fetch_packet_out[0].valid, 0);
    chk("sq_req_addr", icache_req_addr, 32'h200);
    chk("sq_free", free_slots, 8);
    tick();
    drive(0, 0, 1, 0);
    chk("miss_hold_addr", icache_req_addr, 32'h200);
    tick();
    drive(1, 32'h10, 0, 0);
    tick();
    drive(0, 0, 1, 0);
    chk("wfi_req_addr", icache_req_addr, 32'h10);
    tick();
    drive(0, 0, 0, 0);
    chk("wfi_s0_pc", fetch_packet_out[0].pc, 32'h10);
    chk("wfi_s0_inst", fetch_packet_out[0].inst, WFI);
    chk("wfi_s1_valid", fetch_packet_out[1].valid, HALT ? 0 : 1);
    chk("wfi_req_valid", icache_req_valid, HALT ? 0 : 1);
    tick();
    repeat (2) begin
      drive(0, 0, 1, 0);
      tick();
    end
    drive(1, 32'h40, 1, 0);
    tick();
    drive(0, 0, 1, 0);
    chk("resume_req_valid", icache_req_valid, 1);
    chk("resume_req_addr", icache_req_addr, 32'h40);
    tick();
    repeat (800) begin
      int lim;
      lim = mq_pc.size() < WIDTH ? mq_pc.size() : WIDTH;
      drive($urandom_range(0, 15) == 0, 32'($urandom_range(0, 255)) << 2,
            $urandom_range(0, 3) != 0, $urandom_range(0, lim));
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
